// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sram_port_arbiter                                          |
// | Purpose : Sequences an external async 8-bit SRAM for three ports     |
// |           (video read-only, CPU, download). The ports are served     |
// |           round-robin, and the CPU is locked out while a download    |
// |           is active.                                                 |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sram_port_arbiter #(
  parameter int ADDR_W      = 21,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              vid_req,
  input  logic              cpu_req,
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic              cpu_we,
  input  logic              dl_we,
  input  logic [7:0]        cpu_wdata,
  input  logic [7:0]        dl_wdata,
  output logic              vid_ack,
  output logic              cpu_ack,
  output logic              dl_ack,
  output logic [7:0]        rdata,
  input  logic              dl_active,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [7:0]        sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [7:0]        sram_dq_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_STROBE = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [1:0] P_VID = 2'd0;
  localparam logic [1:0] P_CPU = 2'd1;
  localparam logic [1:0] P_DL  = 2'd2;

  // The strobe counter is loaded with the number of strobe edges still to
  // come after the first one, so a value of zero marks the last edge.
  localparam logic [3:0] STROBE_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state;
  logic [1:0]        last;      // port granted most recently
  logic [1:0]        grant;     // port owning the access in flight
  logic              we_flag;
  logic [3:0]        wait_cnt;

  logic [2:0]        elig;
  logic              pick_valid;
  logic [1:0]        pick;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [7:0]        sel_wdata;

  // The CPU drops out of arbitration while a download owns the memory.
  assign elig       = {dl_req, cpu_req & ~dl_active, vid_req};
  assign pick_valid = |elig;

  // Round-robin choice: start searching at the port after the last winner.
  always_comb begin
    pick = P_VID;
    case (last)
      P_VID: begin
        if (elig[1])      pick = P_CPU;
        else if (elig[2]) pick = P_DL;
        else              pick = P_VID;
      end
      P_CPU: begin
        if (elig[2])      pick = P_DL;
        else if (elig[0]) pick = P_VID;
        else              pick = P_CPU;
      end
      default: begin
        if (elig[0])      pick = P_VID;
        else if (elig[1]) pick = P_CPU;
        else              pick = P_DL;
      end
    endcase
  end

  // Route the chosen port's address and write fields to the latch inputs.
  always_comb begin
    sel_addr  = vid_addr;
    sel_we    = 1'b0;
    sel_wdata = 8'h00;
    case (pick)
      P_CPU: begin
        sel_addr  = cpu_addr;
        sel_we    = cpu_we;
        sel_wdata = cpu_wdata;
      end
      P_DL: begin
        sel_addr  = dl_addr;
        sel_we    = dl_we;
        sel_wdata = dl_wdata;
      end
      default: ;
    endcase
  end

  // Access sequencer. All pin-facing outputs are registered here.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      last       <= P_DL;      // the next search starts at vid
      grant      <= P_VID;
      we_flag    <= 1'b0;
      wait_cnt   <= 4'd0;
      busy       <= 1'b0;
      sram_addr  <= '0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_dq_o  <= 8'h00;
      sram_dq_oe <= 1'b0;
      rdata      <= 8'h00;
      vid_ack    <= 1'b0;
      cpu_ack    <= 1'b0;
      dl_ack     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state      <= S_ADDR;
            busy       <= 1'b1;
            grant      <= pick;
            last       <= pick;
            sram_addr  <= sel_addr;
            sram_dq_o  <= sel_wdata;
            we_flag    <= sel_we;
            sram_dq_oe <= sel_we;  // drive data a full cycle before we_n falls
          end
        end
        S_ADDR: begin
          state    <= S_STROBE;
          wait_cnt <= STROBE_LAST;
          if (we_flag) sram_we_n <= 1'b0;
          else         sram_oe_n <= 1'b0;
        end
        S_STROBE: begin
          if (wait_cnt == 4'd0) begin
            state     <= S_END;
            sram_we_n <= 1'b1;
            sram_oe_n <= 1'b1;
            if (!we_flag) rdata <= sram_dq_i;
            vid_ack   <= (grant == P_VID);
            cpu_ack   <= (grant == P_CPU);
            dl_ack    <= (grant == P_DL);
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        S_END: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          sram_dq_oe <= 1'b0;      // write data is held through END
          vid_ack    <= 1'b0;
          cpu_ack    <= 1'b0;
          dl_ack     <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_sram_port_arbiter                                       |
// | Purpose : Scoreboard bench for sram_port_arbiter. The main instance  |
// |           uses WAIT_CYCLES=1 and a second instance uses WAIT_CYCLES=4.|
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_sram_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        vid_req = 1'b0, cpu_req = 1'b0, dl_req = 1'b0;
  logic [20:0] vid_addr = '0, cpu_addr = '0, dl_addr = '0;
  logic        cpu_we = 1'b0, dl_we = 1'b0;
  logic [7:0]  cpu_wdata = 8'h00, dl_wdata = 8'h00;
  logic        dl_active = 1'b0;
  logic        vid_ack, cpu_ack, dl_ack, busy;
  logic [7:0]  rdata;
  logic [20:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_dq_oe;
  logic [7:0]  sram_dq_o;
  logic [7:0]  sram_dq_i;

  // SRAM data model: either a fixed value or a function of the address.
  logic        use_fn = 1'b0;
  logic [7:0]  dq_val = 8'h00;
  assign sram_dq_i = use_fn ? (sram_addr[7:0] ^ 8'h5A) : dq_val;

  // Second instance with a long strobe, exercised only through its CPU port.
  logic        w4_cpu_req = 1'b0;
  logic [20:0] w4_cpu_addr = '0;
  logic [7:0]  w4_dq_i = 8'h00;
  logic        w4_vid_ack, w4_cpu_ack, w4_dl_ack, w4_busy;
  logic [7:0]  w4_rdata, w4_dq_o;
  logic [20:0] w4_addr;
  logic        w4_we_n, w4_oe_n, w4_dq_oe;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] rd;
  } exp_t;
  exp_t       sb[$];
  logic [7:0] model_rdata = 8'h00;
  exp_t       mon_e;
  logic [1:0] mon_p;

  always #5 clk_sys = ~clk_sys;

  sram_port_arbiter #(.ADDR_W(21), .WAIT_CYCLES(1)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .vid_req(vid_req), .cpu_req(cpu_req), .dl_req(dl_req),
    .vid_addr(vid_addr), .cpu_addr(cpu_addr), .dl_addr(dl_addr),
    .cpu_we(cpu_we), .dl_we(dl_we), .cpu_wdata(cpu_wdata), .dl_wdata(dl_wdata),
    .vid_ack(vid_ack), .cpu_ack(cpu_ack), .dl_ack(dl_ack), .rdata(rdata),
    .dl_active(dl_active), .busy(busy), .sram_addr(sram_addr),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i)
  );

  sram_port_arbiter #(.ADDR_W(21), .WAIT_CYCLES(4)) dut4 (
    .clk_sys(clk_sys), .reset(reset),
    .vid_req(1'b0), .cpu_req(w4_cpu_req), .dl_req(1'b0),
    .vid_addr(21'h0), .cpu_addr(w4_cpu_addr), .dl_addr(21'h0),
    .cpu_we(1'b0), .dl_we(1'b0), .cpu_wdata(8'h00), .dl_wdata(8'h00),
    .vid_ack(w4_vid_ack), .cpu_ack(w4_cpu_ack), .dl_ack(w4_dl_ack), .rdata(w4_rdata),
    .dl_active(1'b0), .busy(w4_busy), .sram_addr(w4_addr),
    .sram_we_n(w4_we_n), .sram_oe_n(w4_oe_n), .sram_dq_o(w4_dq_o),
    .sram_dq_oe(w4_dq_oe), .sram_dq_i(w4_dq_i)
  );

  // Scoreboard consumer and pin-safety monitor for the main instance.
  always @(negedge clk_sys) begin
    if (vid_ack || cpu_ack || dl_ack) begin
      checks++;
      if ($countones({vid_ack, cpu_ack, dl_ack}) != 1) begin
        errors++;
        $display("FAIL ack_onehot got %b exp one-hot", {vid_ack, cpu_ack, dl_ack});
      end
      mon_p = cpu_ack ? 2'd1 : (dl_ack ? 2'd2 : 2'd0);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_ack got port %0d exp no ack", mon_p);
      end else begin
        mon_e = sb.pop_front();
        if (mon_p !== mon_e.port || rdata !== mon_e.rd) begin
          errors++;
          $display("FAIL sb_ack got port %0d rdata %h exp port %0d rdata %h",
                   mon_p, rdata, mon_e.port, mon_e.rd);
        end
      end
    end
    if (!sram_we_n || !sram_oe_n) begin
      checks++;
      if ((!sram_oe_n && sram_dq_oe) || (!sram_we_n && !sram_dq_oe) ||
          (!sram_we_n && !sram_oe_n)) begin
        errors++;
        $display("FAIL pin_safety got we_n %b oe_n %b dq_oe %b exp legal strobe",
                 sram_we_n, sram_oe_n, sram_dq_oe);
      end
    end
  end

  function automatic logic ack_of(input int p);
    return (p == 0) ? vid_ack : ((p == 1) ? cpu_ack : dl_ack);
  endfunction

  task automatic push(input logic [1:0] p, input logic we, input logic [7:0] rd);
    exp_t e;
    if (!we) model_rdata = rd;
    e.port = p;
    e.rd   = model_rdata;
    sb.push_back(e);
  endtask

  task automatic set_req(input int p, input logic v, input logic [20:0] a,
                         input logic we, input logic [7:0] wd);
    case (p)
      0: begin vid_req = v; vid_addr = a; end
      1: begin cpu_req = v; cpu_addr = a; cpu_we = we; cpu_wdata = wd; end
      default: begin dl_req = v; dl_addr = a; dl_we = we; dl_wdata = wd; end
    endcase
  endtask

  task automatic do_reset();
    vid_req = 1'b0; cpu_req = 1'b0; dl_req = 1'b0; w4_cpu_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1 reset = 1'b0;
    model_rdata = 8'h00;
  endtask

  // Single access; k counts cycles after the edge that samples the request.
  task automatic run_access(input int p, input logic [20:0] a, input logic we,
                            input logic [7:0] wd, output int ack_at, output int oe_cnt,
                            output int we_cnt, output int dqoe_cnt, output int ack_n,
                            output logic [20:0] addr_k1, output logic [7:0] dq_at_we,
                            output logic strobes_k1);
    ack_at = 0; oe_cnt = 0; we_cnt = 0; dqoe_cnt = 0; ack_n = 0;
    addr_k1 = '0; dq_at_we = 8'h00; strobes_k1 = 1'b0;
    @(posedge clk_sys); #1;
    set_req(p, 1'b1, a, we, wd);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk_sys); #1;
      if (ack_at != 0) set_req(p, 1'b0, a, we, wd);
      @(negedge clk_sys);
      if (k == 1) begin
        addr_k1    = sram_addr;
        strobes_k1 = sram_we_n & sram_oe_n;
      end
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) begin we_cnt++; dq_at_we = sram_dq_o; end
      if (sram_dq_oe) dqoe_cnt++;
      if (ack_of(p)) begin
        ack_n++;
        if (ack_at == 0) ack_at = k;
      end
    end
    set_req(p, 1'b0, a, we, wd);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk_sys);
    checks++;
    if ({sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_o, vid_ack, cpu_ack,
         dl_ack, rdata, busy} !== {21'h0, 1'b1, 1'b1, 1'b0, 8'h00, 3'b000, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got addr %h we_n %b oe_n %b dq_oe %b dq_o %h acks %b rdata %h busy %b exp 0 1 1 0 00 000 00 0",
               sram_addr, sram_we_n, sram_oe_n, sram_dq_oe, sram_dq_o,
               {vid_ack, cpu_ack, dl_ack}, rdata, busy);
    end
    do_reset();
    @(negedge clk_sys);
    checks++;
    if ({busy, w4_busy, sram_we_n, sram_oe_n} !== 4'b0011) begin
      errors++;
      $display("FAIL idle_after_reset got busy %b w4_busy %b we_n %b oe_n %b exp 0 0 1 1",
               busy, w4_busy, sram_we_n, sram_oe_n);
    end
  endtask

  task automatic test_cpu_read();
    int ack_at, oe_cnt, we_cnt, dqoe_cnt, ack_n;
    logic [20:0] a1;
    logic [7:0]  dqw;
    logic        s1;
    use_fn = 1'b0; dq_val = 8'hA5;
    push(2'd1, 1'b0, 8'hA5);
    run_access(1, 21'h01234, 1'b0, 8'h00, ack_at, oe_cnt, we_cnt, dqoe_cnt, ack_n, a1, dqw, s1);
    checks++;
    if (a1 !== 21'h01234 || s1 !== 1'b1) begin
      errors++;
      $display("FAIL rd_addr_phase got addr %h strobes_high %b exp 01234 1", a1, s1);
    end
    checks++;
    if (oe_cnt != 1 || we_cnt != 0 || dqoe_cnt != 0) begin
      errors++;
      $display("FAIL rd_strobes got oe %0d we %0d dqoe %0d exp 1 0 0", oe_cnt, we_cnt, dqoe_cnt);
    end
    checks++;
    if (ack_at != 3 || ack_n != 1) begin
      errors++;
      $display("FAIL rd_latency got ack_at %0d count %0d exp 3 1", ack_at, ack_n);
    end
    checks++;
    if (rdata !== 8'hA5) begin
      errors++;
      $display("FAIL rd_hold got %h exp a5", rdata);
    end
  endtask

  task automatic test_dl_write();
    int ack_at, oe_cnt, we_cnt, dqoe_cnt, ack_n;
    logic [20:0] a1;
    logic [7:0]  dqw;
    logic        s1;
    dq_val = 8'hEE;
    push(2'd2, 1'b1, 8'h00);
    run_access(2, 21'h1FFFFF, 1'b1, 8'h3C, ack_at, oe_cnt, we_cnt, dqoe_cnt, ack_n, a1, dqw, s1);
    checks++;
    if (dqoe_cnt != 3 || we_cnt != 1 || oe_cnt != 0) begin
      errors++;
      $display("FAIL wr_strobes got dqoe %0d we %0d oe %0d exp 3 1 0", dqoe_cnt, we_cnt, oe_cnt);
    end
    checks++;
    if (a1 !== 21'h1FFFFF || dqw !== 8'h3C) begin
      errors++;
      $display("FAIL wr_addr_data got addr %h dq %h exp 1fffff 3c", a1, dqw);
    end
    checks++;
    if (ack_at != 3 || ack_n != 1 || rdata !== 8'hA5) begin
      errors++;
      $display("FAIL wr_ack got ack_at %0d count %0d rdata %h exp 3 1 a5", ack_at, ack_n, rdata);
    end
  endtask

  task automatic test_saturated();
    int n, cnt[3];
    do_reset();
    use_fn = 1'b1;
    n = 0; cnt[0] = 0; cnt[1] = 0; cnt[2] = 0;
    for (int r = 0; r < 3; r++) begin
      push(2'd0, 1'b0, 8'h10 ^ 8'h5A);
      push(2'd1, 1'b0, 8'h20 ^ 8'h5A);
      push(2'd2, 1'b0, 8'h30 ^ 8'h5A);
    end
    @(posedge clk_sys); #1;
    set_req(0, 1'b1, 21'h00010, 1'b0, 8'h00);
    set_req(1, 1'b1, 21'h00020, 1'b0, 8'h00);
    set_req(2, 1'b1, 21'h00030, 1'b0, 8'h00);
    for (int k = 0; k < 60 && !(n == 9 && !vid_req); k++) begin
      @(posedge clk_sys); #1;
      if (n == 9) begin vid_req = 1'b0; cpu_req = 1'b0; dl_req = 1'b0; end
      @(negedge clk_sys);
      if (vid_ack) cnt[0]++;
      if (cpu_ack) cnt[1]++;
      if (dl_ack)  cnt[2]++;
      if (vid_ack || cpu_ack || dl_ack) n++;
    end
    vid_req = 1'b0; cpu_req = 1'b0; dl_req = 1'b0;
    checks++;
    if (n != 9 || cnt[0] != 3 || cnt[1] != 3 || cnt[2] != 3) begin
      errors++;
      $display("FAIL saturated_counts got total %0d vid %0d cpu %0d dl %0d exp 9 3 3 3",
               n, cnt[0], cnt[1], cnt[2]);
    end
    repeat (4) @(posedge clk_sys);
  endtask

  task automatic test_dl_lockout();
    int n, t[3];
    n = 0;
    push(2'd0, 1'b0, 8'h40 ^ 8'h5A);
    push(2'd0, 1'b0, 8'h40 ^ 8'h5A);
    push(2'd1, 1'b0, 8'h50 ^ 8'h5A);
    @(posedge clk_sys); #1;
    dl_active = 1'b1;
    set_req(0, 1'b1, 21'h00040, 1'b0, 8'h00);
    set_req(1, 1'b1, 21'h00050, 1'b0, 8'h00);
    for (int k = 1; k <= 40 && n < 3; k++) begin
      @(posedge clk_sys); #1;
      if (n == 2) begin vid_req = 1'b0; dl_active = 1'b0; end
      @(negedge clk_sys);
      if (vid_ack || cpu_ack) begin
        t[n] = k;
        n++;
      end
    end
    @(posedge clk_sys); #1;
    cpu_req = 1'b0; vid_req = 1'b0; dl_active = 1'b0;
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL lockout_timeout got %0d acks exp 3", n);
    end else begin
      checks++;
      if (t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
        errors++;
        $display("FAIL lockout_spacing got %0d %0d exp 4 4", t[1] - t[0], t[2] - t[1]);
      end
    end
    repeat (4) @(posedge clk_sys);
  endtask

  task automatic test_wait4();
    int ack_at, oe_cnt, ack_n;
    logic [7:0] q[$];
    logic [7:0] expv;
    ack_at = 0; oe_cnt = 0; ack_n = 0;
    w4_dq_i = 8'h11;
    @(posedge clk_sys); #1;
    w4_cpu_req = 1'b1; w4_cpu_addr = 21'h00ABC;
    q.push_back(8'hC3);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_sys); #1;
      if (k == 3) w4_dq_i = 8'h22;
      if (k == 5) w4_dq_i = 8'hC3;
      if (k == 7) w4_dq_i = 8'hFF;
      if (ack_at != 0) w4_cpu_req = 1'b0;
      @(negedge clk_sys);
      if (!w4_oe_n) oe_cnt++;
      if (w4_cpu_ack) begin
        ack_n++;
        if (ack_at == 0) ack_at = k;
        if (q.size() > 0) begin
          expv = q.pop_front();
          checks++;
          if (w4_rdata !== expv) begin
            errors++;
            $display("FAIL w4_capture got %h exp %h", w4_rdata, expv);
          end
        end
      end
    end
    w4_cpu_req = 1'b0;
    checks++;
    if (oe_cnt != 4 || ack_at != 6 || ack_n != 1) begin
      errors++;
      $display("FAIL w4_timing got oe %0d ack_at %0d count %0d exp 4 6 1", oe_cnt, ack_at, ack_n);
    end
    checks++;
    if (w4_rdata !== 8'hC3) begin
      errors++;
      $display("FAIL w4_hold got %h exp c3", w4_rdata);
    end
  endtask

  task automatic test_reset_mid_write();
    int acks_n, we_cnt;
    logic [7:0] dqw;
    logic done;
    acks_n = 0; we_cnt = 0; dqw = 8'h00; done = 1'b0;
    @(posedge clk_sys); #1;
    set_req(1, 1'b1, 21'h00055, 1'b1, 8'h77);
    @(posedge clk_sys);
    @(posedge clk_sys);
    #2;
    checks++;
    if (sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_strobe got we_n %b dq_oe %b exp 0 1", sram_we_n, sram_dq_oe);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({sram_we_n, sram_oe_n, sram_dq_oe, busy} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_abort got we_n %b oe_n %b dq_oe %b busy %b exp 1 1 0 0",
               sram_we_n, sram_oe_n, sram_dq_oe, busy);
    end
    repeat (2) begin
      @(negedge clk_sys);
      if (cpu_ack) acks_n++;
    end
    @(posedge clk_sys); #1;
    reset = 1'b0;
    model_rdata = 8'h00;
    push(2'd1, 1'b1, 8'h00);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk_sys); #1;
      if (done) cpu_req = 1'b0;
      @(negedge clk_sys);
      if (!sram_we_n) begin we_cnt++; dqw = sram_dq_o; end
      if (cpu_ack) begin done = 1'b1; acks_n++; end
    end
    cpu_req = 1'b0;
    checks++;
    if (acks_n != 1 || we_cnt != 1 || dqw !== 8'h77) begin
      errors++;
      $display("FAIL reset_resume got acks %0d we %0d dq %h exp 1 1 77", acks_n, we_cnt, dqw);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dl_write();
    test_saturated();
    test_dl_lockout();
    test_wait4();
    test_reset_mid_write();
    repeat (4) @(posedge clk_sys);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
